// File: rtl/sdp_ram_fifo_ctrl.sv
// sdp_ram_fifo_ctrl
// FIFO controller that sits in front of a simple-dual-port RAM. The RAM has a
// registered read port. Words are written through port A. They are read
// through port B and presented downstream with a registered valid flag.
// The read data path is taken directly from the RAM output register.
//
// Optional feature: define SDP_RAM_FIFO_CTRL_FLUSH_EN to add a flush_i input.
// flush_i discards every stored word and the presented word in one cycle.
module sdp_ram_fifo_ctrl #(
  parameter int MEMORY_WIDTH = 72,
  parameter int ADDRS_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
`ifdef SDP_RAM_FIFO_CTRL_FLUSH_EN
  input  logic                    flush_i,
`endif
  // upstream write handshake
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  input  logic [MEMORY_WIDTH-1:0] s_data_i,
  // downstream read handshake
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [MEMORY_WIDTH-1:0] m_data_o,
  // RAM write port
  output logic                    ram_ena_o,
  output logic                    ram_wea_o,
  output logic [ADDRS_WIDTH-1:0]  ram_addra_o,
  output logic [MEMORY_WIDTH-1:0] ram_dia_o,
  // RAM read port (registered output)
  output logic                    ram_enb_o,
  output logic [ADDRS_WIDTH-1:0]  ram_addrb_o,
  input  logic [MEMORY_WIDTH-1:0] ram_dob_i,
  // status
  output logic [ADDRS_WIDTH:0]    count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int CNT_W = ADDRS_WIDTH + 1;

  // The pointers carry one extra wrap bit.
  // This lets a completely full RAM be told apart from an empty one.
  localparam logic [CNT_W-1:0] DEPTH_C = {1'b1, {ADDRS_WIDTH{1'b0}}};
  localparam logic [CNT_W-1:0] ONE_C   = {{ADDRS_WIDTH{1'b0}}, 1'b1};

  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             m_valid_q, m_valid_d;

  logic [CNT_W-1:0] mem_cnt;
  logic             s_ready;
  logic             wr_fire;
  logic             rd_fire;

  // Handshake decisions come from registered occupancy only.
  // So a read never hits the address being written in the same cycle.
  always_comb begin
    mem_cnt = wr_ptr_q - rd_ptr_q;
    s_ready = (mem_cnt < DEPTH_C) && rst_n_i;
    rd_fire = (mem_cnt != '0) && (!m_valid_q || m_ready_i);
`ifdef SDP_RAM_FIFO_CTRL_FLUSH_EN
    if (flush_i) begin
      s_ready = 1'b0;
      rd_fire = 1'b0;
    end
`endif
    wr_fire = s_valid_i && s_ready;
  end

  // Next-state computation for the pointers and the presented-word flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    m_valid_d = m_valid_q;
    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end
    if (rd_fire) begin
      rd_ptr_d  = rd_ptr_q + ONE_C;
      m_valid_d = 1'b1;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
`ifdef SDP_RAM_FIFO_CTRL_FLUSH_EN
    if (flush_i) begin
      rd_ptr_d  = wr_ptr_q;
      m_valid_d = 1'b0;
    end
`endif
  end

  // State registers.
  // Reset discards all words but leaves the RAM contents untouched.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign s_ready_o   = s_ready;

  assign ram_ena_o   = wr_fire;
  assign ram_wea_o   = wr_fire;
  assign ram_addra_o = wr_ptr_q[ADDRS_WIDTH-1:0];
  assign ram_dia_o   = s_data_i;

  assign ram_enb_o   = rd_fire;
  assign ram_addrb_o = rd_ptr_q[ADDRS_WIDTH-1:0];

  // The RAM output register only advances on a read.
  // A read is never issued while the word is stalled, so the data holds.
  assign m_valid_o   = m_valid_q;
  assign m_data_o    = ram_dob_i;

  assign count_o     = mem_cnt + CNT_W'(m_valid_q);
  assign full_o      = (mem_cnt == DEPTH_C);
  assign empty_o     = (count_o == '0);

endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// Testbench for sdp_ram_fifo_ctrl with a 4-deep, 8-bit configuration.
// The bench has a behavioural RAM and a queue-based reference model.
// A checker process compares the model with the DUT every cycle.
// Directed sections pin the model with literal expected values.
module tb_sdp_ram_fifo_ctrl;

  localparam int MW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fl;
  logic          s_valid, s_ready;
  logic [MW-1:0] s_data;
  logic          m_valid, m_ready;
  logic [MW-1:0] m_data;
  logic          ram_ena, ram_wea, ram_enb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [MW-1:0] ram_dia, ram_dob;
  logic [AW:0]   count;
  logic          full, empty;

  int checks = 0;
  int passed = 0;

  sdp_ram_fifo_ctrl #(.MEMORY_WIDTH(MW), .ADDRS_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
`ifdef SDP_RAM_FIFO_CTRL_FLUSH_EN
    .flush_i     (fl),
`endif
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .ram_ena_o   (ram_ena),
    .ram_wea_o   (ram_wea),
    .ram_addra_o (ram_addra),
    .ram_dia_o   (ram_dia),
    .ram_enb_o   (ram_enb),
    .ram_addrb_o (ram_addrb),
    .ram_dob_i   (ram_dob),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  always #5 clk = ~clk;

  // Simple-dual-port RAM with a registered read port.
  logic [MW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_ena && ram_wea) ram[ram_addra] <= ram_dia;
    if (ram_enb) ram_dob <= ram[ram_addrb];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Inputs change just after the falling edge.
  // They are then allowed to settle before anything samples them.
  task automatic applyStimulus(input logic sv, input logic [MW-1:0] d,
                               input logic mr, input logic f);
    @(negedge clk);
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    fl      = f;
    #4;
  endtask

  // Reference model.
  // mq holds the words stored in RAM that are not yet read.
  // ov/od is the word currently presented downstream.
  logic [MW-1:0] mq[$];
  logic          ov = 1'b0;
  logic [MW-1:0] od = '0;
  int unsigned   wr_total = 0;
  int unsigned   rd_total = 0;
  int            cyc = 0;
  logic [MW-1:0] rx[$];
  int            rx_cyc[$];
  logic          e_ready, e_rd, e_wr;

  // Checker: compares just before each rising edge, then advances the model.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        mq.delete(); ov = 1'b0; wr_total = 0; rd_total = 0;
      end
      e_ready = rst_n && (mq.size() < DEPTH) && !fl;
      e_rd    = (mq.size() > 0) && (!ov || m_ready) && !fl;
      e_wr    = s_valid && e_ready;
      checkOutput("s_ready", s_ready, e_ready);
      checkOutput("ram_ena", ram_ena, e_wr);
      checkOutput("ram_wea", ram_wea, e_wr);
      if (e_wr) begin
        checkOutput("ram_addra", ram_addra, wr_total % DEPTH);
        checkOutput("ram_dia", ram_dia, s_data);
      end
      checkOutput("ram_enb", ram_enb, e_rd);
      if (e_rd) checkOutput("ram_addrb", ram_addrb, rd_total % DEPTH);
      checkOutput("m_valid", m_valid, ov);
      if (ov) checkOutput("m_data", m_data, od);
      checkOutput("count", count, mq.size() + int'(ov));
      checkOutput("full", full, mq.size() == DEPTH);
      checkOutput("empty", empty, (mq.size() + int'(ov)) == 0);
      if (m_valid && m_ready && rst_n && !fl) begin
        rx.push_back(m_data);
        rx_cyc.push_back(cyc);
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        mq.delete(); ov = 1'b0; wr_total = 0; rd_total = 0;
      end else if (fl) begin
        mq.delete(); ov = 1'b0; rd_total = wr_total;
      end else begin
        if (e_rd) begin
          od = mq.pop_front(); ov = 1'b1; rd_total++;
        end else if (m_ready) begin
          ov = 1'b0;
        end
        if (e_wr) begin
          mq.push_back(s_data); wr_total++;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    int i;
    int guard;
    rst_n = 1'b0; fl = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_ram_enb", ram_enb, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release_s_ready", s_ready, 1);

    // Single word: valid appears two cycles after the write and then holds.
    $display("[TB] single word");
    rx.delete(); rx_cyc.delete();
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("sw_wea", ram_wea, 1);
    checkOutput("sw_addra", ram_addra, 0);
    checkOutput("sw_dia", ram_dia, 8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sw_c1_valid", m_valid, 0);
    checkOutput("sw_c1_count", count, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sw_c2_valid", m_valid, 1);
    checkOutput("sw_c2_data", m_data, 8'hA5);
    checkOutput("sw_c2_count", count, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sw_c3_data", m_data, 8'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("sw_drain_empty", empty, 1);
    checkOutput("sw_rx_size", rx.size(), 1);

    // Fill: four words in RAM plus one presented; the sixth is refused.
    $display("[TB] fill");
    rx.delete(); rx_cyc.delete();
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
      if (k == 5) checkOutput("fill_k5_ready", s_ready, 1);
      if (k == 6) begin
        checkOutput("fill_k6_ready", s_ready, 0);
        checkOutput("fill_k6_wea", ram_wea, 0);
        checkOutput("fill_full", full, 1);
        checkOutput("fill_count", count, 5);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fill_hold_count", count, 5);
    repeat (8) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fill_rx_size", rx.size(), 5);
    for (int k = 0; k < rx.size(); k++) checkOutput("fill_rx_data", rx[k], k + 1);
    checkOutput("fill_empty", empty, 1);

    // Streaming: one word per cycle, pointers wrap twice.
    $display("[TB] streaming");
    rx.delete(); rx_cyc.delete();
    for (int k = 0; k < 16; k++) applyStimulus(1'b1, 8'(k), 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_rx_size", rx.size(), 16);
    for (int k = 0; k < rx.size(); k++) checkOutput("stream_rx_data", rx[k], k);
    if (rx.size() == 16) checkOutput("stream_no_bubble", rx_cyc[15] - rx_cyc[0], 15);

    // Backpressure: random downstream ready over 100 words.
    $display("[TB] backpressure");
    rx.delete(); rx_cyc.delete();
    i = 0; guard = 0;
    while (i < 100 && guard < 2000) begin
      applyStimulus(1'b1, 8'(i), 1'($urandom_range(0, 1)), 1'b0);
      if (s_ready) i++;
      guard++;
    end
    checkOutput("bp_sent", i, 100);
    guard = 0;
    while (rx.size() < 100 && guard < 300) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      guard++;
    end
    checkOutput("bp_rx_size", rx.size(), 100);
    for (int k = 0; k < rx.size(); k++) checkOutput("bp_rx_data", rx[k], k);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("bp_empty", empty, 1);

    // Reset mid-operation: stored words are dropped.
    $display("[TB] reset mid-operation");
    rx.delete(); rx_cyc.delete();
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("rst_pre_count", count, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", m_valid, 0);
    checkOutput("rst_mid_count", count, 0);
    checkOutput("rst_mid_empty", empty, 1);
    checkOutput("rst_mid_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_rel_ready", s_ready, 1);
    checkOutput("rst_rel_valid", m_valid, 0);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
    repeat (5) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rst_rx_size", rx.size(), 1);
    if (rx.size() > 0) checkOutput("rst_rx_data", rx[0], 8'h33);

`ifdef SDP_RAM_FIFO_CTRL_FLUSH_EN
    // Flush: everything is discarded and the concurrent write is refused.
    $display("[TB] flush");
    rx.delete(); rx_cyc.delete();
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(8'h51 + k), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fl_pre_count", count, 4);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
    checkOutput("fl_ready", s_ready, 0);
    checkOutput("fl_ena", ram_ena, 0);
    checkOutput("fl_enb", ram_enb, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fl_count", count, 0);
    checkOutput("fl_empty", empty, 1);
    repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fl_rx_size", rx.size(), 0);
    applyStimulus(1'b1, 8'h66, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fl_after_size", rx.size(), 1);
    if (rx.size() > 0) checkOutput("fl_after_data", rx[0], 8'h66);
`endif

    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sdp_ram_fifo_ctrl.md
SDP_RAM_FIFO_CTRL -- requirements
Module: sdp_ram_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter MEMORY_WIDTH, default 72, meaning the data word width in bits.
REQ-002 The block SHALL have parameter ADDRS_WIDTH, default 8, meaning the RAM address width, giving DEPTH = 2**ADDRS_WIDTH.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n_i, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have ports s_valid_i (input, 1), s_ready_o (output, 1) and s_data_i (input, MEMORY_WIDTH): the upstream write handshake.
REQ-007 The block SHALL have ports m_valid_o (output, 1), m_ready_i (input, 1) and m_data_o (output, MEMORY_WIDTH): the downstream read handshake.
REQ-008 The block SHALL have RAM write-side outputs ram_ena_o (1), ram_wea_o (1), ram_addra_o (ADDRS_WIDTH) and ram_dia_o (MEMORY_WIDTH).
REQ-009 The block SHALL have RAM read-side outputs ram_enb_o (1) and ram_addrb_o (ADDRS_WIDTH), and input ram_dob_i (MEMORY_WIDTH) from the registered RAM read port.
REQ-010 The block SHALL have status outputs count_o (ADDRS_WIDTH+1), full_o (1) and empty_o (1).

Function
REQ-011 A write SHALL occur in every cycle with s_valid_i && s_ready_o; in that cycle ram_ena_o = ram_wea_o = 1, ram_addra_o = wr_ptr[ADDRS_WIDTH-1:0] and ram_dia_o = s_data_i (combinational).
REQ-012 The pointers wr_ptr and rd_ptr SHALL each be ADDRS_WIDTH+1 bits, increment by 1 per accepted write or issued read, and wrap modulo 2**(ADDRS_WIDTH+1).
REQ-013 The RAM occupancy SHALL be mem_cnt = wr_ptr - rd_ptr, so 0..DEPTH words are stored in RAM and not yet read out.
REQ-014 s_ready_o SHALL be (mem_cnt < DEPTH) && rst_n_i, and full_o SHALL be (mem_cnt == DEPTH).
REQ-015 A read SHALL be issued (ram_enb_o = 1, ram_addrb_o = rd_ptr[ADDRS_WIDTH-1:0]) iff mem_cnt > 0 && (!m_valid_o || m_ready_i).
REQ-016 m_valid_o SHALL be registered: it is set on the edge after an issued read, and cleared on the edge where m_ready_i = 1 and no read is issued.
REQ-017 m_data_o SHALL equal ram_dob_i directly, and SHALL stay stable while m_valid_o && !m_ready_i, because ram_enb_o is low in that case.
REQ-018 Latency SHALL be fixed: a write accepted in cycle N into an empty block gives m_valid_o = 1 in cycle N+2, since mem_cnt is seen nonzero in N+1 and the RAM returns data at the N+1 edge.
REQ-019 A simultaneous write and read in one cycle SHALL leave mem_cnt unchanged; a read never targets the address being written that cycle, because mem_cnt is registered.
REQ-020 With continuous s_valid_i and m_ready_i, throughput SHALL be one word per cycle with no bubbles after the first word.
REQ-021 count_o SHALL be mem_cnt + m_valid_o (0..DEPTH+1), and empty_o SHALL be (count_o == 0).
REQ-022 When full, s_valid_i SHALL be ignored, with no pointer change and ram_wea_o = 0; when empty, m_ready_i SHALL be ignored.

Reset
REQ-023 While rst_n_i = 0, the block SHALL asynchronously set wr_ptr = rd_ptr = 0 and m_valid_o = 0, giving count_o = 0, empty_o = 1, full_o = 0, s_ready_o = 0 and ram_ena_o = ram_wea_o = ram_enb_o = 0.
REQ-024 Reset asserted mid-operation SHALL discard all stored words; RAM contents are not cleared, and after release no stale word is presented.
REQ-025 s_ready_o SHALL rise in the first cycle after rst_n_i deasserts.

Configuration
REQ-026 When macro SDP_RAM_FIFO_CTRL_FLUSH_EN is defined, the block SHALL add input flush_i (1 bit); a cycle with flush_i = 1 sets rd_ptr <= wr_ptr and m_valid_o <= 0 on the next edge, forces ram_enb_o = 0, and blocks writes that cycle (s_ready_o = 0).
REQ-027 When SDP_RAM_FIFO_CTRL_FLUSH_EN is undefined, the block SHALL omit flush_i and all flush logic, and behave as REQ-011..REQ-022.

Verification (ADDRS_WIDTH=2, DEPTH=4, MEMORY_WIDTH=8)
REQ-028 Single word: write 0xA5 in cycle 0 with m_ready_i = 0 -> m_valid_o = 1 from cycle 2, m_data_o = 0xA5 held, count_o = 1.
REQ-029 Fill: write 0x01..0x06 with m_ready_i = 0 -> 5 words accepted (4 in RAM + 1 presented), full_o = 1, s_ready_o = 0, count_o = 5, and 0x06 is rejected.
REQ-030 Streaming: 16 writes 0x00..0x0F with m_ready_i = 1 throughout -> outputs 0x00..0x0F in order at one per cycle, and pointers wrap twice.
REQ-031 Backpressure: random m_ready_i over 100 words -> no loss, no duplication, order preserved, and m_data_o stable while stalled.
REQ-032 Reset: rst_n_i pulsed low with count_o = 3 -> m_valid_o = 0 and count_o = 0 at once; after release, write 0x33 gives m_data_o = 0x33 only.
REQ-033 Flush (SDP_RAM_FIFO_CTRL_FLUSH_EN defined): count_o = 4, flush_i for 1 cycle -> next cycle count_o = 0 and empty_o = 1; a write in the flush cycle is not accepted.
